// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// Provides the FSM state encoding and a generic slice extractor.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam int MAXW = 256;

  function automatic logic [MAXW-1:0] slice_of(
    input logic [MAXW-1:0] vec,
    input int              idx,
    input int              w
  );
    logic [MAXW-1:0] mask;
    mask = ~({MAXW{1'b1}} << w);
    return (vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: feeds a WIDTH-bit slice adder LS slice first,
// chaining carries; ports: start/op_a/op_b/cin -> result/cout/done/err, add_* to adder.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   cin_en,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [WIDTH*WORDS-1:0] result,
  output logic                   cout,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  output logic                   add_carry_listen,
  output logic                   add_on_off,
  input  logic [WIDTH-1:0]       add_c,
  input  logic                   add_cout,
  input  logic                   add_ack
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             cin_en_q;
  logic             cin_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [CNT_W-1:0] wait_q;
  logic [N-1:0]     result_q;
  logic             cout_q;
  logic             err_q;
  logic             last;
  logic             expired;

  assign last    = (idx_q == IDX_W'(WORDS - 1));
  // wait_q counts stalled cycles of the current slice; giving up once it
  // hits TIMEOUT puts done TIMEOUT+1 cycles after the slice first appears.
  assign expired = (wait_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (add_ack) begin
          if (last) state_d = DONE;
        end else if (expired) begin
          state_d = DONE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_en_q <= 1'b0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      wait_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            cin_en_q <= cin_en;
            cin_q    <= cin;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            wait_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        ISSUE: begin
          if (add_ack) begin
            result_q[idx_q*WIDTH +: WIDTH] <= add_c;
            carry_q <= add_cout;
            wait_q  <= '0;
            if (last) begin
              cout_q <= add_cout;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (expired) begin
            err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    add_a            = '0;
    add_b            = '0;
    add_cin          = 1'b0;
    add_carry_listen = 1'b0;
    add_on_off       = 1'b0;
    if (state_q == ISSUE) begin
      add_a      = WIDTH'(slice_of(MAXW'(a_q), 32'(idx_q), WIDTH));
      add_b      = WIDTH'(slice_of(MAXW'(b_q), 32'(idx_q), WIDTH));
      add_on_off = 1'b1;
      if (idx_q == '0) begin
        add_carry_listen = cin_en_q;
        add_cin          = cin_q;
      end else begin
        add_carry_listen = 1'b1;
        add_cin          = carry_q;
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer with a behavioural 16-bit slice adder
// whose ack can be withheld; expected sums flow through a scoreboard queue.
module tb_wide_add_sequencer;

  localparam int WIDTH   = 16;
  localparam int WORDS   = 4;
  localparam int TIMEOUT = 8;
  localparam int N       = WIDTH * WORDS;

  typedef struct packed {
    logic         err;
    logic [N-1:0] res;
    logic         cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             cin_en;
  logic             cin;
  logic             busy;
  logic             done;
  logic             err;
  logic [N-1:0]     result;
  logic             cout;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             add_carry_listen;
  logic             add_on_off;
  logic [WIDTH-1:0] add_c;
  logic             add_cout;
  logic             add_ack;
  logic             ack_en;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .WIDTH  (WIDTH),
    .WORDS  (WORDS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .op_a            (op_a),
    .op_b            (op_b),
    .cin_en          (cin_en),
    .cin             (cin),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .result          (result),
    .cout            (cout),
    .add_a           (add_a),
    .add_b           (add_b),
    .add_cin         (add_cin),
    .add_carry_listen(add_carry_listen),
    .add_on_off      (add_on_off),
    .add_c           (add_c),
    .add_cout        (add_cout),
    .add_ack         (add_ack)
  );

  logic [WIDTH:0] adder_sum;
  always_comb begin
    adder_sum = '0;
    if (add_on_off) begin
      adder_sum = {1'b0, add_a} + {1'b0, add_b}
                + (WIDTH+1)'(add_carry_listen & add_cin);
    end
  end
  assign add_c    = adder_sum[WIDTH-1:0];
  assign add_cout = adder_sum[WIDTH];
  assign add_ack  = add_on_off & ack_en;

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic ce, input logic c, input int stall,
                     input int exp_cyc, input int pulse_at);
    logic [N:0]       s;
    logic [WIDTH:0]   s0;
    exp_t             e;
    exp_t             got;
    int               n;
    s  = {1'b0, a} + {1'b0, b} + (N+1)'(ce & c);
    s0 = {1'b0, a[WIDTH-1:0]} + {1'b0, b[WIDTH-1:0]} + (WIDTH+1)'(ce & c);
    if (stall >= 0) begin
      e.err  = 1'b1;
      e.res  = s[N-1:0] & ((N'(1) << (WIDTH * stall)) - N'(1));
      e.cout = 1'b0;
    end else begin
      e.err  = 1'b0;
      e.res  = s[N-1:0];
      e.cout = s[N];
    end
    sb.push_back(e);
    @(negedge clk);
    op_a = a; op_b = b; cin_en = ce; cin = c;
    start = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    n = 1;
    chk("slice0_a", N'(add_a), N'(a[WIDTH-1:0]));
    chk("slice0_b", N'(add_b), N'(b[WIDTH-1:0]));
    chk("slice0_listen", N'(add_carry_listen), N'(ce));
    forever begin
      ack_en = !(stall >= 0 && n - 1 >= stall);
      start  = (n == pulse_at);
      if (n == pulse_at) op_a = ~a;
      if (n == 2) begin
        chk("slice1_listen", N'(add_carry_listen), N'(1));
        chk("slice1_cin", N'(add_cin), N'(s0[WIDTH]));
      end
      if (done || n >= 40) break;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_cycle", N'(n), N'(exp_cyc));
    chk("busy_at_done", N'(busy), N'(1));
    got = '{err: err, res: result, cout: cout};
    e = sb.pop_front();
    chk("result", got.res, e.res);
    chk("cout", N'(got.cout), N'(e.cout));
    chk("err", N'(got.err), N'(e.err));
    @(negedge clk);
    ack_en = 1'b1;
    chk("done_single", N'(done), N'(0));
    chk("idle_after", N'(busy), N'(0));
    chk("result_held", result, e.res);
    chk("err_held", N'(err), N'(e.err));
  endtask

  initial begin
    logic saw_done;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    cin_en = 1'b0; cin = 1'b0; ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_err", N'(err), N'(0));
    chk("rst_result", result, N'(0));
    chk("rst_cout", N'(cout), N'(0));
    chk("rst_on_off", N'(add_on_off), N'(0));
    chk("rst_add_a", N'(add_a), N'(0));
    reset = 1'b0;

    run(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, -1, 5, -1);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, -1, 5, -1);
    run(64'h0, 64'h0, 1'b1, 1'b1, -1, 5, -1);
    run(64'h0, 64'h0, 1'b0, 1'b1, -1, 5, -1);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, -1, 5, -1);
    run(64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_0001,
        1'b0, 1'b0, 2, 12, -1);
    run(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
        1'b0, 1'b0, -1, 5, 2);

    @(negedge clk);
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1;
    cin_en = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_on_off", N'(add_on_off), N'(1));
    chk("mid_slice2_a", N'(add_a), N'(16'hFFFF));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", N'(busy), N'(0));
    chk("mid_rst_done", N'(done), N'(0));
    chk("mid_rst_result", result, N'(0));
    chk("mid_rst_on_off", N'(add_on_off), N'(0));
    chk("mid_rst_add_a", N'(add_a), N'(0));
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", N'(saw_done), N'(0));
    run(64'h1234, 64'h1, 1'b0, 1'b0, -1, 5, -1);

    chk("sb_empty", N'(sb.size()), N'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
